// File: rtl/dht11_read_sequencer_pkg.sv
// Shared definitions for the DHT11 read sequencer and its receiver:
// state encoding, failure causes, frame size and the checksum rule.
package dht11_read_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_RECEIVE,
        S_CHECK,
        S_FAIL,
        S_HOLDOFF
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ACK  = 2'b01;
    localparam logic [1:0] ERR_BIT  = 2'b10;
    localparam logic [1:0] ERR_SUM  = 2'b11;

    localparam int FRAME_BITS = 40;

    // Checksum byte is the modulo-256 sum of the four data bytes.
    function automatic logic sum_ok(input logic [39:0] frame);
        logic [7:0] s;
        s = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return s == frame[7:0];
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dht11_read_sequencer_if.sv
// Bundle of request/result and start/receiver signals around the sequencer.
// master = sequencer side, slave = host, start generator and bit receiver side.
interface dht11_read_sequencer_if;
    logic       read_req;
    logic       start_trig;
    logic       start_confirm;
    logic       rx_en;
    logic       rx_bit_valid;
    logic       rx_bit;
    logic       busy;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       data_valid;
    logic       have_data;
    logic       err_pulse;
    logic [1:0] err_code;

    modport master (
        input  read_req, start_confirm, rx_bit_valid, rx_bit,
        output start_trig, rx_en, busy, hum_int, hum_dec, temp_int, temp_dec,
               data_valid, have_data, err_pulse, err_code
    );

    modport slave (
        output read_req, start_confirm, rx_bit_valid, rx_bit,
        input  start_trig, rx_en, busy, hum_int, hum_dec, temp_int, temp_dec,
               data_valid, have_data, err_pulse, err_code
    );
endinterface

// File: rtl/dht11_read_sequencer_interval_timer.sv
// Loadable down-counter shared by the ack, bit and holdoff timeouts.
// A value N loaded at one edge makes the owner act on expiry N edges later.
module dht11_interval_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // Flag one count early so the consuming state changes on the Nth edge.
    assign expired = (cnt <= W'(1));
endmodule

// File: rtl/dht11_read_sequencer.sv
// Sequences complete DHT11 reads: start pulse, ack wait, 40-bit capture,
// checksum, bounded retries and the minimum interval between attempts.
module dht11_read_sequencer
    import dht11_read_sequencer_pkg::*;
#(
    parameter int HOLDOFF_CYC     = 1000000,
    parameter int ACK_TIMEOUT_CYC = 20000,
    parameter int BIT_TIMEOUT_CYC = 200,
    parameter int MAX_RETRY       = 2,
    parameter int AUTO_MODE       = 0
) (
    input logic clk,
    input logic rst,
    dht11_read_sequencer_if.master bus
);
    localparam int TW = $clog2(max3(HOLDOFF_CYC, ACK_TIMEOUT_CYC, BIT_TIMEOUT_CYC) + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t          state, nxt;
    logic [39:0]     sr;
    logic [5:0]      bit_cnt;
    logic [RW-1:0]   retry_cnt;
    logic            retry_pend;
    logic            pending;
    logic [7:0]      hum_int, hum_dec, temp_int, temp_dec;
    logic            data_valid, have_data, err_pulse;
    logic [1:0]      err_code;

    logic            tmr_load, tmr_exp;
    logic [TW-1:0]   tmr_val;
    logic [1:0]      cause;
    logic            consume, clr_retry;

    dht11_interval_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .value   (tmr_val),
        .expired (tmr_exp)
    );

    always_comb begin
        nxt       = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        cause     = ERR_NONE;
        consume   = 1'b0;
        clr_retry = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.read_req || pending || (AUTO_MODE != 0)) begin
                    nxt       = S_START;
                    consume   = 1'b1;
                    clr_retry = 1'b1;
                end
            end
            S_START: begin
                nxt      = S_WAIT_ACK;
                tmr_load = 1'b1;
                tmr_val  = TW'(ACK_TIMEOUT_CYC);
            end
            S_WAIT_ACK: begin
                if (bus.start_confirm) begin
                    nxt      = S_RECEIVE;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(BIT_TIMEOUT_CYC);
                end else if (tmr_exp) begin
                    nxt   = S_FAIL;
                    cause = ERR_ACK;
                end
            end
            S_RECEIVE: begin
                if (bus.rx_bit_valid) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(BIT_TIMEOUT_CYC);
                    if (bit_cnt == 6'(FRAME_BITS - 1))
                        nxt = S_CHECK;
                end else if (tmr_exp) begin
                    nxt   = S_FAIL;
                    cause = ERR_BIT;
                end
            end
            S_CHECK: begin
                if (sum_ok(sr)) begin
                    nxt      = S_HOLDOFF;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(HOLDOFF_CYC);
                end else begin
                    nxt   = S_FAIL;
                    cause = ERR_SUM;
                end
            end
            S_FAIL: begin
                nxt      = S_HOLDOFF;
                tmr_load = 1'b1;
                tmr_val  = TW'(HOLDOFF_CYC);
            end
            S_HOLDOFF: begin
                // A retry outranks a queued request; neither can cut the holdoff short.
                if (tmr_exp) begin
                    if (retry_pend) begin
                        nxt = S_START;
                    end else if (pending || (AUTO_MODE != 0)) begin
                        nxt       = S_START;
                        consume   = 1'b1;
                        clr_retry = 1'b1;
                    end else begin
                        nxt = S_IDLE;
                    end
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
            pending    <= 1'b0;
            hum_int    <= '0;
            hum_dec    <= '0;
            temp_int   <= '0;
            temp_dec   <= '0;
            data_valid <= 1'b0;
            have_data  <= 1'b0;
            err_pulse  <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state      <= nxt;
            data_valid <= 1'b0;
            err_pulse  <= 1'b0;
            pending    <= (pending && !consume) || (bus.read_req && (state != S_IDLE));
            if (clr_retry)
                retry_cnt <= '0;
            if (state == S_WAIT_ACK && nxt == S_RECEIVE)
                bit_cnt <= '0;
            if (state == S_RECEIVE && bus.rx_bit_valid) begin
                sr      <= {sr[38:0], bus.rx_bit};
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (nxt == S_FAIL && state != S_FAIL)
                err_code <= cause;
            if (state == S_CHECK && nxt == S_HOLDOFF) begin
                hum_int    <= sr[39:32];
                hum_dec    <= sr[31:24];
                temp_int   <= sr[23:16];
                temp_dec   <= sr[15:8];
                data_valid <= 1'b1;
                have_data  <= 1'b1;
                err_code   <= ERR_NONE;
            end
            if (state == S_FAIL) begin
                if (retry_cnt < RW'(MAX_RETRY)) begin
                    retry_cnt  <= retry_cnt + 1'b1;
                    retry_pend <= 1'b1;
                end else begin
                    err_pulse  <= 1'b1;
                    retry_pend <= 1'b0;
                end
            end
            if (state == S_HOLDOFF && tmr_exp)
                retry_pend <= 1'b0;
        end
    end

    assign bus.start_trig = (state == S_START);
    assign bus.rx_en      = (state == S_RECEIVE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.hum_int    = hum_int;
    assign bus.hum_dec    = hum_dec;
    assign bus.temp_int   = temp_int;
    assign bus.temp_dec   = temp_dec;
    assign bus.data_valid = data_valid;
    assign bus.have_data  = have_data;
    assign bus.err_pulse  = err_pulse;
    assign bus.err_code   = err_code;
endmodule

// File: doc/dht11_read_sequencer.md
Name: dht11_read_sequencer

Overview:
Controller that schedules and sequences complete DHT11 read transactions. It triggers the start-pulse generator, waits for its sensor-response confirmation, then enables the bit receiver and shifts in the 40-bit frame. It verifies the checksum, retries failed reads, and enforces the sensor's minimum interval between reads. It sits between the top level (request/auto mode, result registers) and the start/receiver blocks on the 1 MHz tick domain.

Parameters:
HOLDOFF_CYC, 1000000, minimum cycles from end of one attempt to next start pulse (1 s at 1 MHz)
ACK_TIMEOUT_CYC, 20000, max cycles from start_trig to start_confirm
BIT_TIMEOUT_CYC, 200, max cycles between consecutive rx_bit_valid (and from rx_en rise to first bit)
MAX_RETRY, 2, extra attempts after a failed attempt (0 = no retry)
AUTO_MODE, 0, 1 = re-arm a read automatically after every holdoff

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
read_req  in  1  one-cycle request for a read transaction
start_trig  out  1  one-cycle pulse to the start-pulse generator
start_confirm  in  1  one-cycle pulse: sensor response detected
rx_en  out  1  level: receiver enabled
rx_bit_valid  in  1  one-cycle strobe: rx_bit holds a decoded bit
rx_bit  in  1  decoded data bit, MSB first
busy  out  1  high whenever state != IDLE
hum_int  out  8  humidity integer byte (frame bits 39:32)
hum_dec  out  8  humidity decimal byte (31:24)
temp_int  out  8  temperature integer byte (23:16)
temp_dec  out  8  temperature decimal byte (15:8)
data_valid  out  1  one-cycle pulse: result registers updated
have_data  out  1  level: at least one good frame since reset
err_pulse  out  1  one-cycle pulse: transaction failed after all retries
err_code  out  2  last failure cause: 00 none, 01 ack timeout, 10 bit timeout, 11 checksum

Behaviour:
- Reset (rst=1 at an edge) from any state, mid-frame included:
  - state=IDLE; all outputs 0 (result bytes 0, err_code 00).
  - shift register, bit counter, retry counter and pending flag cleared; holdoff not armed.
- IDLE:
  - read_req or pending flag (or AUTO_MODE=1) -> START. Clear pending; retry_cnt=0.
  - First read after reset needs no holdoff.
- START: assert start_trig for exactly 1 cycle; load timer=ACK_TIMEOUT_CYC; -> WAIT_ACK.
- WAIT_ACK:
  - start_confirm -> RECEIVE. rx_en=1 from next cycle; bit_cnt=0; timer=BIT_TIMEOUT_CYC.
  - Timer reaches 0 without confirm -> FAIL with cause 01.
- RECEIVE:
  - On rx_bit_valid: shift {sr[38:0],rx_bit}; bit_cnt++; reload timer.
  - When the 40th bit is accepted: rx_en=0 next cycle -> CHECK.
  - Timer expiry before 40 bits -> FAIL with cause 10.
  - rx_bit_valid outside RECEIVE is ignored.
- CHECK (1 cycle): (sr[39:32]+sr[31:24]+sr[23:16]+sr[15:8]) mod 256 == sr[7:0].
  - Match: load four result bytes; data_valid=1; have_data=1; err_code=00; -> HOLDOFF.
  - Mismatch -> FAIL with cause 11. Result registers keep old values.
- FAIL (1 cycle): err_code=cause.
  - retry_cnt < MAX_RETRY: retry_cnt++; retry_pend=1.
  - Otherwise: err_pulse=1; retry_pend=0.
  - -> HOLDOFF.
- HOLDOFF: load timer=HOLDOFF_CYC on entry. On expiry:
  - retry_pend -> START.
  - pending or AUTO_MODE -> START with retry_cnt=0.
  - Otherwise -> IDLE.
- read_req while busy (any state except IDLE): sets pending flag. One-deep; extra requests are absorbed.
- read_req in the same cycle as rst: ignored.
- A new read_req never shortens HOLDOFF; start_trig spacing is always >= HOLDOFF_CYC cycles.
- Timer semantics: loaded value N expires N cycles after load. Bits 41+ cannot occur (state has left RECEIVE).
- start_confirm outside WAIT_ACK is ignored.

Decomposition:
- Shared include dht11_defs.vh holds:
  - state encodings (IDLE, START, WAIT_ACK, RECEIVE, CHECK, FAIL, HOLDOFF)
  - err_code constants
  - FRAME_BITS=40
- Also shared with the receiver.
- One sub-module: dht11_interval_timer, a loadable down-counter with load and value inputs and an expired output. It is instantiated once and reused for the ACK, bit and holdoff timeouts.
- Width is $clog2 of the largest parameter.

Test Plan (bench params HOLDOFF_CYC=50, ACK_TIMEOUT_CYC=20, BIT_TIMEOUT_CYC=10, MAX_RETRY=1):
- Good frame: read_req, confirm after 5 cycles, bits of 0x28_00_1A_05_47 -> hum_int=0x28, temp_int=0x1A, temp_dec=0x05; data_valid 1 cycle; err_pulse never; busy drops 50 cycles after CHECK.
- Ack timeout: read_req, no confirm -> start_trig at t0 and again >=50 cycles after first FAIL; after second timeout err_pulse=1, err_code=01, result bytes unchanged.
- Bad checksum then good: first frame checksum 0x48 (bad), retry frame correct -> one FAIL with no err_pulse, then data_valid; err_code ends 00.
- Bit timeout: stop bits after 17 -> FAIL cause 10 exactly 10 cycles after bit 17; rx_en low afterwards.
- Request while busy + reset mid-frame: read_req pulsed three times during RECEIVE -> exactly one extra transaction. Separately, rst asserted after bit 20 -> all outputs 0 next cycle and a following read_req starts cleanly with bit_cnt=0.
